// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID and PC sequencing for load-use, mul/div, branch-flush and imem-wait hazards
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_op,
  input  logic [4:0]       i_rs,
  input  logic [4:0]       i_rt,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_ex_br_taken,
  input  logic             i_imem_ready,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_md_busy,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, MDBUSY = 2'd2} state_t;
  state_t state, state_nx;
  logic [5:0] md_cnt;
  logic uses_rt, md_issue, hilo_rd, lu, md, run, md_load;
  assign uses_rt  = i_op[0] | (i_op inside {8'h08, 8'h0A, 8'h56, 8'h50, 8'h52});
  assign md_issue = i_op inside {8'h31, 8'h33, 8'h35, 8'h37};
  assign hilo_rd  = i_op inside {8'h21, 8'h25};
  assign lu = i_ex_memread & (i_ex_rt != 5'd0) & ((i_ex_rt == i_rs) | (uses_rt & (i_ex_rt == i_rt)));
  assign o_md_busy = md_cnt != 6'd0;
  assign md = o_md_busy & (hilo_rd | md_issue);
  assign run = state != BOOT;
  // a flushed or stalled issue never starts the unit
  assign md_load = run & md_issue & ~i_ex_br_taken & ~lu & ~md;
  assign o_state = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nx;
  always_comb
    state_nx = (state == BOOT) ? RUN :
               md_load ? MDBUSY :
               (state == MDBUSY && md_cnt == 6'd1) ? RUN : state;
  always_comb
    {o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble} =
      !run                ? 4'b0011 :
      i_ex_br_taken       ? 4'b1011 :
      (lu | md)           ? 4'b0001 :
      !i_imem_ready       ? 4'b0010 : 4'b1100;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      md_cnt      <= '0;
      o_stall_cnt <= '0;
    end else begin
      md_cnt      <= md_load ? 6'(MD_LAT) : md_cnt - {5'd0, o_md_busy};
      o_stall_cnt <= o_stall_cnt + CNT_W'(o_idex_bubble & run);
    end
endmodule
